serial_add_ctrl: RTL

Bit-serial addition controller that time-shares one 1-bit full adder (`fa`) to add two WIDTH-bit operands, one bit per clock, LSB first. It latches operands on a start request and drives the adder's `a`/`b`/`c` inputs from internal shift registers. It collects the adder's `s`/`cout` outputs into a result register and signals completion with a single-cycle `done` pulse. It sits between a requester (register file or test sequencer) and a single external `fa` instance.

---
 rtl/serial_add_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// serial_add_ctrl : bit-serial adder controller, one full-adder bit per clock
// Revision        : 1.0  initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] sh_d;
  logic             w_run;

  // Incoming sum bit enters at the MSB so that after WIDTH shifts bit 0 is LSB.
  generate
    if (WIDTH == 1) begin : g_sh_single
      assign sh_d = fa_s;
    end else begin : g_sh_multi
      assign sh_d = {fa_s, sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sh_q    <= sh_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == C_LAST) begin
            sum_q   <= sh_d;
            cout_q  <= fa_cout;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Adder inputs come only from registers, never from fa_s/fa_cout.
  assign w_run = (state_q == S_RUN);
  assign fa_a  = w_run & a_q[0];
  assign fa_b  = w_run & b_q[0];
  assign fa_c  = w_run & carry_q;

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule
`default_nettype wire
